sysid_regs: RTL and testbench
=============================

SYSID_REGS -- requirements
Module: sysid_regs

Interface
REQ-001 Parameter ID, 32'h0270_1AAA: system identifier returned at word 0.
REQ-002 Parameter TIMESTAMP, 32'h0: build timestamp in Unix seconds, returned at word 1.
REQ-003 Parameter NUM_USER, 2: count of user constant words, range 0..8.
REQ-004 Parameter USER_WORDS, {NUM_USER{32'h0}}: packed user constants; word k occupies bits [32k+31:32k].
REQ-005 Parameter ADDR_W, 4: word-address width; the SHALL value is at least 4.
REQ-006 clk  input  1  single system clock; all logic on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 address  input  ADDR_W  Avalon-MM word address.
REQ-009 read  input  1  read strobe, one cycle per transfer.
REQ-010 write  input  1  write strobe, one cycle per transfer.
REQ-011 writedata  input  32  write data.
REQ-012 byteenable  input  4  byte lanes for writes.
REQ-013 readdata  output  32  registered read data.
REQ-014 readdatavalid  output  1  one-cycle pulse qualifying readdata.

Function
REQ-015 Register map:
- 0 ID (RO).
- 1 TIMESTAMP (RO).
- 2 CAPS (RO): [7:0]=NUM_USER, [15:8]=ADDR_W, [31:16]=16'h0001 (map version).
- 3 SCRATCH (RW).
- 4 UPTIME_LO (RO).
- 5 UPTIME_HI (RO, snapshot).
- 6 CTRL (RW): bit0 FREEZE, bit1 CLEAR (self-clearing), other bits read 0.
- 7..6+NUM_USER USER[k] (RO).
- All other addresses read 0.
REQ-016 No waitrequest; every read gets fixed latency 1: read at cycle N gives readdatavalid=1 and readdata at cycle N+1.
REQ-017 readdata holds its last value when readdatavalid=0.
REQ-018 If read and write are asserted together, the block treats the transfer as a write only; no readdatavalid follows.
REQ-019 SCRATCH writes honour byteenable per lane; writes to RO or unmapped addresses are ignored with no side effect.
REQ-020 Uptime is a 64-bit cycle counter: +1 per clk while FREEZE=0; wraps from 2^64-1 to 0 with no flag.
REQ-021 A read of UPTIME_LO returns counter[31:0] and captures counter[63:32] into the UPTIME_HI shadow in the same cycle; both halves come from the same counter value.
REQ-022 Reads of UPTIME_HI return the shadow only; the shadow changes only on an UPTIME_LO read or on reset.
REQ-023 A CTRL write with byteenable[0]=1 and writedata[1]=1 zeroes the counter on the next edge, regardless of FREEZE; CLEAR reads 0 afterward.
REQ-024 If the clear and an UPTIME_LO read occur in the same cycle, the block returns and snapshots the pre-clear value; the counter is 0 on the next cycle.
REQ-025 FREEZE=1 holds the counter; clearing FREEZE resumes counting on the next edge.
REQ-026 For NUM_USER=0, addresses 7 and above read 0; no user logic is generated.

Reset
REQ-027 While reset=1: readdatavalid=0, readdata=0, SCRATCH=0, CTRL=0, counter=0, shadow=0.
REQ-028 A read or write presented with reset=1 is discarded; reset asserted mid-read, in the cycle after the read, suppresses that readdatavalid.
REQ-029 The counter first increments on the edge after reset deasserts; the first UPTIME_LO read issued 1 cycle after deassert returns 1.

Verification
REQ-030 Read addresses 0,1,2 with defaults -> 32'h02701AAA, 32'h0, 32'h00010402, each valid exactly 1 cycle after read.
REQ-031 Write SCRATCH 32'hDEADBEEF with byteenable 4'b0101, then read -> 32'h00AD00EF; write to address 0 -> ID read unchanged.
REQ-032 Force counter to 64'h0000_0001_FFFF_FFFF, read LO then HI on consecutive reads -> 32'hFFFFFFFF then 32'h00000001, even though the counter has carried.
REQ-033 Write CTRL=1 (FREEZE), wait 100 cycles, two LO reads -> equal values; write CTRL=2 -> next LO read returns a small value (cycles since clear, under 4), and CTRL reads 0.
REQ-034 Same-cycle read and write to SCRATCH -> no readdatavalid, SCRATCH updated; read at address 15 -> 0.
REQ-035 Assert reset the cycle after a read -> readdatavalid stays 0; all registers read their reset values afterward.

Source files
------------

// File: rtl/sysid_regs.sv
// System identification register block on an Avalon-MM slave port: constant IDs,
// a scratch word, control bits and a 64-bit uptime counter read LO-then-HI.
module sysid_regs #(
    parameter logic [31:0] ID        = 32'h0270_1AAA,
    parameter logic [31:0] TIMESTAMP = 32'h0,
    parameter int unsigned NUM_USER  = 2,
    parameter logic [((NUM_USER > 0) ? NUM_USER : 1)*32-1:0] USER_WORDS = '0,
    parameter int unsigned ADDR_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    output logic [31:0]       readdata,
    output logic              readdatavalid
);

    localparam logic [ADDR_W-1:0] A_ID      = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_TSTAMP  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_CAPS    = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_SCRATCH = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_UP_LO   = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_UP_HI   = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(6);
    localparam int unsigned       A_USER    = 7;

    logic [63:0] uptime;
    logic [31:0] shadow;
    logic [31:0] scratch;
    logic        freeze;
    logic [31:0] rd_q;
    logic        rdv_q;

    logic        rd_en;
    logic        clear;
    logic [31:0] rd_mux;
    logic [31:0] user_word;
    logic        user_hit;

    // A simultaneous read and write is a write only.
    assign rd_en = read & ~write;
    assign clear = write && (address == A_CTRL) && byteenable[0] && writedata[1];

    if (NUM_USER > 0) begin : g_user
        always_comb begin
            user_hit  = 1'b0;
            user_word = '0;
            for (int k = 0; k < int'(NUM_USER); k++) begin
                if (address == ADDR_W'(int'(A_USER) + k)) begin
                    user_hit  = 1'b1;
                    user_word = USER_WORDS[32*k +: 32];
                end
            end
        end
    end else begin : g_no_user
        assign user_hit  = 1'b0;
        assign user_word = '0;
    end

    always_comb begin
        // NOTE: default assigned first so no path through the case infers a latch.
        rd_mux = '0;
        case (address)
            A_ID:      rd_mux = ID;
            A_TSTAMP:  rd_mux = TIMESTAMP;
            A_CAPS:    rd_mux = {16'h0001, 8'(ADDR_W), 8'(NUM_USER)};
            A_SCRATCH: rd_mux = scratch;
            A_UP_LO:   rd_mux = uptime[31:0];
            A_UP_HI:   rd_mux = shadow;
            A_CTRL:    rd_mux = {31'b0, freeze};
            default:   rd_mux = user_hit ? user_word : '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            uptime  <= '0;
            shadow  <= '0;
            scratch <= '0;
            freeze  <= 1'b0;
            rd_q    <= '0;
            rdv_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking, so the LO data, the HI shadow and the clear all
            // act on the same pre-edge counter value.
            rdv_q <= rd_en;
            if (rd_en) begin
                rd_q <= rd_mux;
            end
            if (rd_en && address == A_UP_LO) begin
                shadow <= uptime[63:32];
            end

            if (clear) begin
                uptime <= '0;
            end else if (!freeze) begin
                uptime <= uptime + 64'd1;
            end

            if (write && address == A_SCRATCH) begin
                for (int b = 0; b < 4; b++) begin
                    if (byteenable[b]) begin
                        scratch[8*b +: 8] <= writedata[8*b +: 8];
                    end
                end
            end
            if (write && address == A_CTRL && byteenable[0]) begin
                freeze <= writedata[0];
            end
        end
    end

    // Reset masks the outputs immediately so a read completing under reset is dropped.
    assign readdatavalid = rdv_q & ~reset;
    assign readdata      = reset ? 32'h0 : rd_q;

endmodule

// File: tb/tb_sysid_regs.sv
// Scoreboard bench for sysid_regs: a register-map model predicts each read, a
// monitor sampling just before every rising edge checks latency, data and hold.
module tb_sysid_regs;

    localparam logic [31:0] USER0 = 32'h1234_5678;
    localparam logic [31:0] USER1 = 32'hCAFE_0001;
    localparam logic [63:0] FORCE_VAL = 64'h0000_0001_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [3:0]  byteenable = '0;
    logic [31:0] readdata;
    logic        readdatavalid;

    sysid_regs #(
        .NUM_USER  (2),
        .USER_WORDS({USER1, USER0}),
        .ADDR_W    (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .read         (read),
        .write        (write),
        .writedata    (writedata),
        .byteenable   (byteenable),
        .readdata     (readdata),
        .readdatavalid(readdatavalid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h, expected %08h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    typedef struct {
        int          due;
        logic [31:0] data;
        logic [3:0]  addr;
    } exp_t;
    exp_t sbq[$];

    // Register-map model: counter = cycles since reset/clear spent unfrozen.
    logic [63:0] m_cnt = '0;
    logic [31:0] m_shadow = '0;
    logic [31:0] m_scratch = '0;
    logic        m_freeze = 1'b0;

    function automatic logic [31:0] model_read(input logic [3:0] a);
        case (a)
            4'd0:    return 32'h0270_1AAA;
            4'd1:    return 32'h0;
            4'd2:    return {16'h0001, 8'd4, 8'd2};
            4'd3:    return m_scratch;
            4'd4:    return m_cnt[31:0];
            4'd5:    return m_shadow;
            4'd6:    return {31'b0, m_freeze};
            4'd7:    return USER0;
            4'd8:    return USER1;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_edge(input logic rst, input logic rd, input logic wr,
                              input logic [3:0] a, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] mask;
        if (rst) begin
            m_cnt = '0; m_shadow = '0; m_scratch = '0; m_freeze = 1'b0;
        end else begin
            if (rd && !wr && a == 4'd4) m_shadow = m_cnt[63:32];
            if (wr && a == 4'd6 && be[0] && wd[1]) m_cnt = '0;
            else if (!m_freeze) m_cnt = m_cnt + 64'd1;
            if (wr && a == 4'd3) begin
                mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
                m_scratch = (m_scratch & ~mask) | (wd & mask);
            end
            if (wr && a == 4'd6 && be[0]) m_freeze = wd[0];
        end
    endtask

    // One bus cycle: drive at the falling edge, predict, advance the model.
    task automatic cycle(input logic rst, input logic rd, input logic wr,
                         input logic [3:0] a, input logic [31:0] wd, input logic [3:0] be);
        @(negedge clk);
        reset = rst; read = rd; write = wr; address = a; writedata = wd; byteenable = be;
        if (!rst && rd && !wr) sbq.push_back('{due: cyc + 1, data: model_read(a), addr: a});
        model_edge(rst, rd, wr, a, wd, be);
    endtask

    task automatic rd_word(input logic [3:0] a);
        cycle(1'b0, 1'b1, 1'b0, a, 32'h0, 4'h0);
    endtask

    task automatic wr_word(input logic [3:0] a, input logic [31:0] wd, input logic [3:0] be);
        cycle(1'b0, 1'b0, 1'b1, a, wd, be);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    endtask

    // Monitor: samples one time unit before each rising edge, as the master would.
    logic [31:0] hold = '0;
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (reset) begin
                check("reset_valid", {31'b0, readdatavalid}, 32'd0);
                check("reset_data", readdata, 32'd0);
                while (sbq.size() > 0 && sbq[0].due <= cyc) void'(sbq.pop_front());
                hold = '0;
            end else if (readdatavalid) begin
                if (sbq.size() == 0) begin
                    check("spurious_valid", {31'b0, readdatavalid}, 32'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("valid_latency", 32'(cyc), 32'(e.due));
                    check($sformatf("read_addr%0d", e.addr), readdata, e.data);
                    hold = e.data;
                end
            end else begin
                check("hold_data", readdata, hold);
                if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                    check($sformatf("missing_valid_addr%0d", sbq[0].addr), {31'b0, readdatavalid}, 32'd1);
                    void'(sbq.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
        idle(1);
        rd_word(4'd4);                       // first LO read after reset -> 1
        rd_word(4'd5);
        rd_word(4'd0);
        rd_word(4'd1);
        rd_word(4'd2);

        wr_word(4'd3, 32'hDEAD_BEEF, 4'b0101);
        rd_word(4'd3);
        wr_word(4'd0, 32'hFFFF_FFFF, 4'hF);
        rd_word(4'd0);
        rd_word(4'd2);
        wr_word(4'd2, 32'h0, 4'hF);
        rd_word(4'd2);

        // Counter preloaded just below a 32-bit carry; LO/HI must stay coherent.
        @(posedge clk);
        #1;
        force dut.uptime = FORCE_VAL;
        m_cnt = FORCE_VAL;
        rd_word(4'd4);
        @(posedge clk);
        #1;
        release dut.uptime;
        m_cnt = FORCE_VAL;
        rd_word(4'd5);
        rd_word(4'd4);
        rd_word(4'd5);

        wr_word(4'd6, 32'h1, 4'hF);
        idle(100);
        rd_word(4'd4);
        rd_word(4'd4);
        rd_word(4'd6);
        wr_word(4'd6, 32'h2, 4'hF);
        rd_word(4'd4);
        rd_word(4'd6);
        wr_word(4'd6, 32'h3, 4'hE);          // byte lane 0 disabled: ignored
        rd_word(4'd6);

        cycle(1'b0, 1'b1, 1'b1, 4'd3, 32'h1122_3344, 4'hF);
        idle(1);
        rd_word(4'd3);
        rd_word(4'd15);
        rd_word(4'd14);
        rd_word(4'd7);
        rd_word(4'd8);
        rd_word(4'd9);

        for (int i = 0; i < 1500; i++) begin
            int unsigned op;
            logic [3:0]  a;
            op = $urandom_range(0, 9);
            a  = 4'($urandom_range(0, 15));
            cycle(1'b0, (op < 5) || (op == 9), (op >= 5) && (op != 8), a,
                  $urandom, 4'($urandom_range(0, 15)));
        end

        // Reset one cycle after a read suppresses its valid; then everything reads reset values.
        rd_word(4'd3);
        cycle(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
        cycle(1'b1, 1'b1, 1'b0, 4'd0, 32'h0, 4'h0);
        cycle(1'b1, 1'b0, 1'b1, 4'd3, 32'hFFFF_FFFF, 4'hF);
        idle(1);
        rd_word(4'd5);
        for (int a = 0; a < 16; a++) rd_word(4'(a));
        idle(4);

        check("queue_drained", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
